// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/2-write register file with accumulator and load scoreboard.
// A per-register busy bit tracks outstanding loads. Decode stalls when it touches a busy register.
// Optional feature: define REG_FILE_BYPASS_EN to forward returning load data to the read ports.
module reg_file_sb #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                acc_read_i,
    input  logic                acc_write_i,
    input  logic [1:0]          reg_write_i,
    input  logic [D-1:0]        src_a_i,
    input  logic [D-1:0]        src_b_i,
    input  logic [W-1:0]        write_value_i,
    input  logic                load_issue_i,
    input  logic [D-1:0]        load_dst_i,
    input  logic                load_done_i,
    input  logic [D-1:0]        load_done_dst_i,
    input  logic [W-1:0]        load_value_i,
    output logic [W-1:0]        read_a_o,
    output logic [W-1:0]        read_b_o,
    output logic                stall_o,
    output logic [(2**D)-1:0]   busy_vec_o,
    output logic                err_flag_o
);

    localparam int unsigned N = 2 ** D;

    logic [W-1:0] rf_q [N];
    logic [W-1:0] rf_d [N];
    logic [W-1:0] acc_q, acc_d;
    logic [N-1:0] busy_q, busy_d;
    logic         err_q, err_d;

    logic         done_hit;
    logic [N-1:0] done_vec;
    logic [N-1:0] busy_rd;
    logic [N-1:0] busy_iss;

    // A returning load only counts when its destination is actually outstanding.
    assign done_hit = load_done_i && busy_q[load_done_dst_i];
    assign done_vec = done_hit ? (N'(1) << load_done_dst_i) : '0;
    // The returning load frees its register for a new issue in the same cycle.
    assign busy_iss = busy_q & ~done_vec;

`ifdef REG_FILE_BYPASS_EN
    // Forwarded registers do not hold up reads.
    assign busy_rd = busy_q & ~done_vec;
`else
    assign busy_rd = busy_q;
`endif

    // Hazard detection: reads, write targets and new load destinations.
    always_comb begin
        stall_o = 1'b0;
        if (!acc_read_i && busy_rd[src_a_i]) stall_o = 1'b1;
        if (busy_rd[src_b_i]) stall_o = 1'b1;
        if (reg_write_i[0] && busy_q[src_a_i]) stall_o = 1'b1;
        if (reg_write_i[1] && busy_q[src_b_i]) stall_o = 1'b1;
        if (load_issue_i && busy_iss[load_dst_i]) stall_o = 1'b1;
    end

    // Combinational read ports, with optional load forwarding.
    always_comb begin
        read_a_o = acc_read_i ? acc_q : rf_q[src_a_i];
        read_b_o = rf_q[src_b_i];
`ifdef REG_FILE_BYPASS_EN
        if (!acc_read_i && done_hit && (load_done_dst_i == src_a_i)) read_a_o = load_value_i;
        if (done_hit && (load_done_dst_i == src_b_i)) read_b_o = load_value_i;
`endif
    end

    // Next-state: load writeback always accepted; decode-side updates gated by stall.
    always_comb begin
        rf_d   = rf_q;
        acc_d  = acc_q;
        busy_d = busy_q;
        err_d  = err_q;
        if (load_done_i) begin
            if (busy_q[load_done_dst_i]) begin
                rf_d[load_done_dst_i]   = load_value_i;
                busy_d[load_done_dst_i] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (!stall_o) begin
            if (reg_write_i[0]) rf_d[src_a_i] = write_value_i;
            if (reg_write_i[1]) rf_d[src_b_i] = write_value_i;
            if (acc_write_i) acc_d = write_value_i;
            if (load_issue_i) busy_d[load_dst_i] = 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_q   <= '{default: '0};
            acc_q  <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rf_q   <= rf_d;
            acc_q  <= acc_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign err_flag_o = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed vectors with literal expectations, a short random
// phase, and a behavioural model checked on every falling edge.
module tb_reg_file_sb;

    logic       clk;
    logic       rst_n;
    logic       acc_read, acc_write, load_issue, load_done;
    logic [1:0] reg_write;
    logic [2:0] src_a, src_b, load_dst, load_done_dst;
    logic [7:0] write_value, load_value;
    logic [7:0] read_a, read_b;
    logic       stall, err_flag;
    logic [7:0] busy_vec;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [7:0] m_rf [8];
    logic [7:0] m_acc;
    logic       m_busy [8];
    logic       m_err;

`ifdef REG_FILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    reg_file_sb #(.W(8), .D(3)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .acc_read_i     (acc_read),
        .acc_write_i    (acc_write),
        .reg_write_i    (reg_write),
        .src_a_i        (src_a),
        .src_b_i        (src_b),
        .write_value_i  (write_value),
        .load_issue_i   (load_issue),
        .load_dst_i     (load_dst),
        .load_done_i    (load_done),
        .load_done_dst_i(load_done_dst),
        .load_value_i   (load_value),
        .read_a_o       (read_a),
        .read_b_o       (read_b),
        .stall_o        (stall),
        .busy_vec_o     (busy_vec),
        .err_flag_o     (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // A load returning this cycle to an outstanding register.
    function automatic bit m_fwd(input logic [2:0] r);
        return load_done && (load_done_dst == r) && m_busy[load_done_dst];
    endfunction

    // A register blocks a read unless its data is being forwarded right now.
    function automatic bit m_rd_blocked(input logic [2:0] r);
        return m_busy[r] && !(Bypass && m_fwd(r));
    endfunction

    function automatic bit m_stall();
        bit s = 1'b0;
        if (!acc_read && m_rd_blocked(src_a)) s = 1'b1;
        if (m_rd_blocked(src_b)) s = 1'b1;
        if (reg_write[0] && m_busy[src_a]) s = 1'b1;
        if (reg_write[1] && m_busy[src_b]) s = 1'b1;
        if (load_issue && m_busy[load_dst] && !m_fwd(load_dst)) s = 1'b1;
        return s;
    endfunction

    function automatic logic [7:0] m_read_a();
        if (acc_read) return m_acc;
        if (Bypass && m_fwd(src_a)) return load_value;
        return m_rf[src_a];
    endfunction

    function automatic logic [7:0] m_read_b();
        if (Bypass && m_fwd(src_b)) return load_value;
        return m_rf[src_b];
    endfunction

    function automatic logic [7:0] m_busy_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Model update on each clock edge, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_rf[i]   = 8'h00;
                m_busy[i] = 1'b0;
            end
            m_acc = 8'h00;
            m_err = 1'b0;
        end else begin
            bit s;
            s = m_stall();
            if (load_done) begin
                if (m_busy[load_done_dst]) begin
                    m_rf[load_done_dst]   = load_value;
                    m_busy[load_done_dst] = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (!s) begin
                if (reg_write[0]) m_rf[src_a] = write_value;
                if (reg_write[1]) m_rf[src_b] = write_value;
                if (acc_write) m_acc = write_value;
                if (load_issue) m_busy[load_dst] = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_read_a", 32'(read_a), 32'(m_read_a()));
        chk("model_read_b", 32'(read_b), 32'(m_read_b()));
        chk("model_stall", 32'(stall), 32'(m_stall()));
        chk("model_busy", 32'(busy_vec), 32'(m_busy_vec()));
        chk("model_err", 32'(err_flag), 32'(m_err));
    end

    task automatic idle();
        acc_read = 0; acc_write = 0; reg_write = 2'b00; src_a = 0; src_b = 0;
        write_value = 0; load_issue = 0; load_dst = 0; load_done = 0;
        load_done_dst = 0; load_value = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Dual write, then reads and accumulator select.
        reg_write = 2'b11; src_a = 1; src_b = 2; write_value = 8'hAA;
        #2 chk("pre_write_rf1", 32'(read_a), 32'h00);
        cyc();
        idle(); src_a = 1; src_b = 2;
        #2 chk("dual_write_rf1", 32'(read_a), 32'hAA);
        chk("dual_write_rf2", 32'(read_b), 32'hAA);
        acc_read = 1;
        #1 chk("acc_read_zero", 32'(read_a), 32'h00);
        cyc();

        // Accumulator and register write in one cycle.
        idle(); acc_write = 1; reg_write = 2'b01; src_a = 6; write_value = 8'h5A;
        cyc();
        idle(); acc_read = 1; src_b = 6;
        #2 chk("acc_written", 32'(read_a), 32'h5A);
        chk("rf6_written", 32'(read_b), 32'h5A);
        cyc();

        // Same-address dual write.
        idle(); reg_write = 2'b11; src_a = 7; src_b = 7; write_value = 8'hC3;
        cyc();
        idle(); src_b = 7;
        #2 chk("same_addr_write", 32'(read_b), 32'hC3);
        cyc();

        // Write to a register with an outstanding load is held off.
        idle(); load_issue = 1; load_dst = 3;
        cyc();
        idle();
        #2 chk("busy_after_issue", 32'(busy_vec), 32'h08);
        src_a = 3; reg_write = 2'b01; write_value = 8'h55; src_b = 0;
        #1 chk("stall_on_busy", 32'(stall), 32'h1);
        cyc();
        load_done = 1; load_done_dst = 3; load_value = 8'h3C;
        #2 chk("stall_in_done_cycle", 32'(stall), 32'h1);
        cyc();
        idle(); src_a = 3;
        #2 chk("load_written", 32'(read_a), 32'h3C);
        chk("stall_drops", 32'(stall), 32'h0);
        chk("busy_cleared", 32'(busy_vec), 32'h00);
        cyc();

        // Forwarding behaviour on a returning load.
        idle(); load_issue = 1; load_dst = 3;
        cyc();
        idle(); src_b = 3; load_done = 1; load_done_dst = 3; load_value = 8'h77;
        #2;
        if (Bypass) begin
            chk("bypass_read_b", 32'(read_b), 32'h77);
            chk("bypass_no_stall", 32'(stall), 32'h0);
        end else begin
            chk("nobypass_stall", 32'(stall), 32'h1);
            chk("nobypass_old_b", 32'(read_b), 32'h3C);
        end
        cyc();
        idle(); src_b = 3;
        #2 chk("load_visible_next", 32'(read_b), 32'h77);
        cyc();

        // Unexpected load return.
        idle(); load_done = 1; load_done_dst = 5; load_value = 8'h99;
        cyc();
        idle(); src_b = 5;
        #2 chk("dropped_write", 32'(read_b), 32'h00);
        chk("err_set", 32'(err_flag), 32'h1);
        repeat (3) cyc();
        chk("err_sticky", 32'(err_flag), 32'h1);

        // Same-cycle issue and return to one register.
        idle(); load_issue = 1; load_dst = 4;
        cyc();
        load_done = 1; load_done_dst = 4; load_value = 8'h11;
        #2 chk("reissue_no_stall", 32'(stall), 32'h0);
        cyc();
        idle(); src_b = 4;
        #2 chk("reissue_data", 32'(read_b), 32'h11);
        chk("reissue_busy", 32'(busy_vec), 32'h10);
        load_done = 1; load_done_dst = 4; load_value = 8'h22;
        cyc();
        idle(); src_b = 4;
        #2 chk("second_return", 32'(read_b), 32'h22);
        cyc();

        // Asynchronous reset mid-cycle with a load outstanding.
        idle(); load_issue = 1; load_dst = 1;
        cyc();
        idle(); src_a = 1; src_b = 2;
        #2 rst_n = 1'b0;
        #1 chk("rst_read_a", 32'(read_a), 32'h00);
        chk("rst_read_b", 32'(read_b), 32'h00);
        chk("rst_busy", 32'(busy_vec), 32'h00);
        chk("rst_err", 32'(err_flag), 32'h0);
        cyc();
        rst_n = 1'b1;
        load_done = 1; load_done_dst = 1; load_value = 8'hEE;
        cyc();
        idle(); src_a = 1;
        #2 chk("post_rst_err", 32'(err_flag), 32'h1);
        chk("post_rst_drop", 32'(read_a), 32'h00);
        cyc();

        // Random traffic checked by the model.
        for (int k = 0; k < 300; k++) begin
            acc_read      = 1'($urandom_range(0, 1));
            acc_write     = 1'($urandom_range(0, 1));
            reg_write     = 2'($urandom_range(0, 3));
            src_a         = 3'($urandom_range(0, 7));
            src_b         = 3'($urandom_range(0, 7));
            write_value   = 8'($urandom_range(0, 255));
            load_issue    = ($urandom_range(0, 3) == 0);
            load_dst      = 3'($urandom_range(0, 7));
            load_done     = ($urandom_range(0, 2) == 0);
            load_done_dst = 3'($urandom_range(0, 7));
            load_value    = 8'($urandom_range(0, 255));
            cyc();
        end
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
